// File: rtl/ex_operand_stage.sv
// ID/EX operand stage: valid/ready capture of a decoded instruction with EX/MEM and
// MEM/WB forwarding, load-use stall detection and ALU control generation.
module ex_operand_stage #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 2,
  parameter int IMM_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_AW-1:0] in_rs,
  input  logic [REG_AW-1:0] in_rt,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [DATA_W-1:0] in_rs_data,
  input  logic [DATA_W-1:0] in_rt_data,
  input  logic [IMM_W-1:0]  in_imm,
  input  logic              in_alu_src,
  input  logic [1:0]        in_alu_op,
  input  logic [5:0]        in_funct,
  input  logic              in_reg_write,
  input  logic              in_mem_read,
  input  logic              in_mem_write,
  input  logic              flush,
  input  logic              exmem_we,
  input  logic              exmem_load,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic [DATA_W-1:0] exmem_data,
  input  logic              memwb_we,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic [DATA_W-1:0] memwb_data,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_control,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write
);

  logic              uses_rt;
  logic              haz_rs;
  logic              haz_rt;
  logic              hazard;
  logic              accept;
  logic [DATA_W-1:0] fwd_rs;
  logic [DATA_W-1:0] fwd_rt;
  logic [DATA_W-1:0] imm_ext;
  logic [3:0]        ctl_next;
  logic [REG_AW-1:0] held_rs;
  logic [REG_AW-1:0] held_rt;
  logic              held_alu_src;
  logic              snoop_rs;
  logic              snoop_rt;

  assign uses_rt = !in_alu_src || in_mem_write;

  // A load sitting here or in EX/MEM cannot supply its data in time.
  assign haz_rs = (in_rs != '0) &&
                  ((ex_valid && ex_mem_read && ex_reg_write && ex_rd == in_rs) ||
                   (exmem_load && exmem_we && exmem_rd == in_rs));
  assign haz_rt = (in_rt != '0) &&
                  ((ex_valid && ex_mem_read && ex_reg_write && ex_rd == in_rt) ||
                   (exmem_load && exmem_we && exmem_rd == in_rt));
  assign hazard   = haz_rs || (uses_rt && haz_rt);
  assign in_ready = !flush && !hazard && (!ex_valid || ex_ready);
  assign accept   = in_valid && in_ready;

  assign fwd_rs = (in_rs == '0) ? in_rs_data :
                  (exmem_we && !exmem_load && exmem_rd == in_rs) ? exmem_data :
                  (memwb_we && memwb_rd == in_rs) ? memwb_data : in_rs_data;
  assign fwd_rt = (in_rt == '0) ? in_rt_data :
                  (exmem_we && !exmem_load && exmem_rd == in_rt) ? exmem_data :
                  (memwb_we && memwb_rd == in_rt) ? memwb_data : in_rt_data;

  assign imm_ext = {{(DATA_W-IMM_W){in_imm[IMM_W-1]}}, in_imm};

  always_comb begin
    ctl_next = 4'b1111;
    case (in_alu_op)
      2'b00: ctl_next = 4'b0010;
      2'b01: ctl_next = 4'b0110;
      2'b11: ctl_next = 4'b0001;
      default: begin
        case (in_funct)
          6'b100000: ctl_next = 4'b0010;
          6'b100010: ctl_next = 4'b0110;
          6'b100100: ctl_next = 4'b0000;
          6'b100101: ctl_next = 4'b0001;
          6'b101010: ctl_next = 4'b0111;
          6'b100111: ctl_next = 4'b1100;
          default:   ctl_next = 4'b1111;
        endcase
      end
    endcase
  end

  // A stalled entry keeps picking up writebacks so its operands never go stale.
  assign snoop_rs = memwb_we && (held_rs != '0) && (memwb_rd == held_rs);
  assign snoop_rt = memwb_we && (held_rt != '0) && (memwb_rd == held_rt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid      <= 1'b0;
      alu_a         <= '0;
      alu_b         <= '0;
      alu_control   <= '0;
      ex_store_data <= '0;
      ex_rd         <= '0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      held_rs       <= '0;
      held_rt       <= '0;
      held_alu_src  <= 1'b0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (accept) begin
      ex_valid      <= 1'b1;
      alu_a         <= fwd_rs;
      alu_b         <= in_alu_src ? imm_ext : fwd_rt;
      alu_control   <= ctl_next;
      ex_store_data <= fwd_rt;
      ex_rd         <= in_rd;
      ex_reg_write  <= in_reg_write;
      ex_mem_read   <= in_mem_read;
      ex_mem_write  <= in_mem_write;
      held_rs       <= in_rs;
      held_rt       <= in_rt;
      held_alu_src  <= in_alu_src;
    end else if (ex_valid && ex_ready) begin
      ex_valid <= 1'b0;
    end else if (ex_valid) begin
      if (snoop_rs) alu_a <= memwb_data;
      if (snoop_rt) begin
        ex_store_data <= memwb_data;
        if (!held_alu_src) alu_b <= memwb_data;
      end
    end
  end

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed and randomized checks of ex_operand_stage against a behavioural model of
// the stage's held entry.
module tb_ex_operand_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [1:0]  in_rs, in_rt, in_rd;
  logic [15:0] in_rs_data, in_rt_data;
  logic [7:0]  in_imm;
  logic        in_alu_src;
  logic [1:0]  in_alu_op;
  logic [5:0]  in_funct;
  logic        in_reg_write, in_mem_read, in_mem_write, flush;
  logic        exmem_we, exmem_load;
  logic [1:0]  exmem_rd;
  logic [15:0] exmem_data;
  logic        memwb_we;
  logic [1:0]  memwb_rd;
  logic [15:0] memwb_data;
  logic        ex_valid, ex_ready;
  logic [15:0] alu_a, alu_b, ex_store_data;
  logic [3:0]  alu_control;
  logic [1:0]  ex_rd;
  logic        ex_reg_write, ex_mem_read, ex_mem_write;

  int total = 0;
  int passed = 0;
  int fails = 0;

  // Model of the held entry
  bit          m_valid;
  logic [15:0] m_a, m_b, m_st;
  logic [3:0]  m_ctl;
  logic [1:0]  m_rd, m_rs, m_rt;
  logic        m_rw, m_mr, m_mw, m_src;

  ex_operand_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_rs_data(in_rs_data), .in_rt_data(in_rt_data), .in_imm(in_imm),
    .in_alu_src(in_alu_src), .in_alu_op(in_alu_op), .in_funct(in_funct),
    .in_reg_write(in_reg_write), .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
    .flush(flush), .exmem_we(exmem_we), .exmem_load(exmem_load), .exmem_rd(exmem_rd),
    .exmem_data(exmem_data), .memwb_we(memwb_we), .memwb_rd(memwb_rd),
    .memwb_data(memwb_data), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
    .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    in_valid = 0; in_rs = 0; in_rt = 0; in_rd = 0; in_rs_data = 0; in_rt_data = 0;
    in_imm = 0; in_alu_src = 0; in_alu_op = 0; in_funct = 0;
    in_reg_write = 0; in_mem_read = 0; in_mem_write = 0; flush = 0;
    exmem_we = 0; exmem_load = 0; exmem_rd = 0; exmem_data = 0;
    memwb_we = 0; memwb_rd = 0; memwb_data = 0; ex_ready = 1;
  endtask

  task automatic model_reset();
    m_valid = 0; m_a = 0; m_b = 0; m_st = 0; m_ctl = 0; m_rd = 0;
    m_rs = 0; m_rt = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_src = 0;
  endtask

  function automatic bit m_blocked(input logic [1:0] src);
    if (src == 0) return 0;
    return (m_valid && m_mr && m_rw && m_rd == src) ||
           (exmem_load && exmem_we && exmem_rd == src);
  endfunction

  function automatic bit m_ready();
    bit rt_used = !in_alu_src || in_mem_write;
    return !flush && !m_blocked(in_rs) && !(rt_used && m_blocked(in_rt)) &&
           (!m_valid || ex_ready);
  endfunction

  // Newest producer wins; a load still in EX/MEM has no data yet.
  function automatic logic [15:0] m_fwd(input logic [1:0] src, input logic [15:0] rf);
    if (src == 0) return rf;
    if (exmem_we && !exmem_load && exmem_rd == src) return exmem_data;
    if (memwb_we && memwb_rd == src) return memwb_data;
    return rf;
  endfunction

  function automatic logic [3:0] m_control(input logic [1:0] op, input logic [5:0] fn);
    if (op == 2'b00) return 4'h2;
    if (op == 2'b01) return 4'h6;
    if (op == 2'b11) return 4'h1;
    case (fn)
      6'h20: return 4'h2;
      6'h22: return 4'h6;
      6'h24: return 4'h0;
      6'h25: return 4'h1;
      6'h2A: return 4'h7;
      6'h27: return 4'hC;
      default: return 4'hF;
    endcase
  endfunction

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic cycle();
    bit rdy;
    #1;
    rdy = m_ready();
    chk("in_ready", in_ready, rdy);
    if (flush) m_valid = 0;
    else if (in_valid && rdy) begin
      m_valid = 1;
      m_a   = m_fwd(in_rs, in_rs_data);
      m_st  = m_fwd(in_rt, in_rt_data);
      m_b   = in_alu_src ? 16'($signed(in_imm)) : m_st;
      m_ctl = m_control(in_alu_op, in_funct);
      m_rd = in_rd; m_rs = in_rs; m_rt = in_rt; m_src = in_alu_src;
      m_rw = in_reg_write; m_mr = in_mem_read; m_mw = in_mem_write;
    end else if (m_valid && ex_ready) m_valid = 0;
    else if (m_valid && memwb_we) begin
      if (m_rs != 0 && memwb_rd == m_rs) m_a = memwb_data;
      if (m_rt != 0 && memwb_rd == m_rt) begin
        m_st = memwb_data;
        if (!m_src) m_b = memwb_data;
      end
    end
    @(posedge clk);
    @(negedge clk);
    chk("ex_valid", ex_valid, m_valid);
    if (m_valid) begin
      chk("alu_a", alu_a, m_a);
      chk("alu_b", alu_b, m_b);
      chk("alu_control", alu_control, m_ctl);
      chk("ex_store_data", ex_store_data, m_st);
      chk("ex_rd", ex_rd, m_rd);
      chk("ctrl_bits", {ex_reg_write, ex_mem_read, ex_mem_write}, {m_rw, m_mr, m_mw});
    end
  endtask

  task automatic randomize_inputs();
    logic [5:0] fl [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h27};
    in_valid = ($urandom_range(0, 3) != 0);
    in_rs = 2'($urandom); in_rt = 2'($urandom); in_rd = 2'($urandom);
    in_rs_data = 16'($urandom); in_rt_data = 16'($urandom); in_imm = 8'($urandom);
    in_alu_src = 1'($urandom); in_alu_op = 2'($urandom);
    in_funct = ($urandom_range(0, 3) != 0) ? fl[$urandom_range(0, 5)] : 6'($urandom);
    in_mem_read = ($urandom_range(0, 2) == 0); in_reg_write = 1'($urandom);
    in_mem_write = ($urandom_range(0, 4) == 0);
    flush = ($urandom_range(0, 7) == 0);
    ex_ready = ($urandom_range(0, 3) != 0);
    exmem_we = 1'($urandom); exmem_load = ($urandom_range(0, 3) == 0);
    exmem_rd = 2'($urandom); exmem_data = 16'($urandom);
    memwb_we = 1'($urandom); memwb_rd = 2'($urandom); memwb_data = 16'($urandom);
  endtask

  initial begin
    // Reset with random inputs
    rst_n = 0;
    model_reset();
    randomize_inputs();
    repeat (3) @(negedge clk);
    chk("rst_ex_valid", ex_valid, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_store", ex_store_data, 0);
    chk("rst_ctl", alu_control, 0);
    chk("rst_rd", ex_rd, 0);
    chk("rst_ctrl_bits", {ex_reg_write, ex_mem_read, ex_mem_write}, 0);
    idle();
    rst_n = 1;
    #1 chk("rst_in_ready", in_ready, 1);

    // R-type add
    idle(); in_valid = 1; in_rs = 1; in_rt = 2; in_rd = 3;
    in_rs_data = 16'h0005; in_rt_data = 16'h0003; in_alu_op = 2'b10; in_funct = 6'h20;
    in_reg_write = 1;
    cycle();
    chk("radd_valid", ex_valid, 1);
    chk("radd_a", alu_a, 16'h0005);
    chk("radd_b", alu_b, 16'h0003);
    chk("radd_ctl", alu_control, 4'b0010);

    // Immediate and unknown funct
    idle(); in_valid = 1; in_rs = 1; in_rs_data = 16'h0001; in_alu_src = 1; in_imm = 8'hFC;
    cycle();
    chk("imm_b", alu_b, 16'hFFFC);
    chk("imm_ctl", alu_control, 4'b0010);
    in_alu_src = 0; in_alu_op = 2'b10; in_funct = 6'h3F;
    cycle();
    chk("bad_funct_ctl", alu_control, 4'b1111);

    // Forwarding priority
    idle(); in_valid = 1; in_rs = 1; in_rs_data = 0; in_alu_src = 1;
    exmem_we = 1; exmem_rd = 1; exmem_data = 16'h1111;
    memwb_we = 1; memwb_rd = 1; memwb_data = 16'h2222;
    cycle();
    chk("fwd_exmem_a", alu_a, 16'h1111);
    exmem_load = 1;
    #1 chk("fwd_load_stall", in_ready, 0);
    cycle();
    exmem_load = 0; in_rs = 0;
    cycle();
    chk("fwd_r0_a", alu_a, 16'h0000);

    // Load-use: two bubbles, operand from MEM/WB
    idle(); in_valid = 1; in_rs = 1; in_rs_data = 16'h0004; in_alu_src = 1; in_imm = 8'h08;
    in_mem_read = 1; in_reg_write = 1; in_rd = 2;
    cycle();
    idle(); in_valid = 1; in_rs = 2; in_rs_data = 16'h0BAD; in_alu_src = 1; in_imm = 8'h01;
    in_rd = 3; in_reg_write = 1;
    #1 chk("lu_stall1", in_ready, 0);
    cycle();
    exmem_we = 1; exmem_load = 1; exmem_rd = 2; exmem_data = 16'h5555;
    #1 chk("lu_stall2", in_ready, 0);
    cycle();
    exmem_we = 0; exmem_load = 0; memwb_we = 1; memwb_rd = 2; memwb_data = 16'hBEEF;
    #1 chk("lu_go", in_ready, 1);
    cycle();
    chk("lu_valid", ex_valid, 1);
    chk("lu_a", alu_a, 16'hBEEF);

    // Backpressure with snoop of the held rs
    idle(); ex_ready = 0; in_valid = 1; in_rs = 1; in_rs_data = 16'h1234;
    #1 chk("bp_ready", in_ready, 0);
    cycle();
    chk("bp_hold_a", alu_a, 16'hBEEF);
    memwb_we = 1; memwb_rd = 2; memwb_data = 16'h7777;
    cycle();
    chk("bp_snoop_a", alu_a, 16'h7777);
    memwb_we = 0;
    cycle();
    chk("bp_hold_valid", ex_valid, 1);
    chk("bp_hold_a2", alu_a, 16'h7777);
    chk("bp_hold_b", alu_b, 16'h0001);

    // Flush beats in_valid and ex_ready
    ex_ready = 1; flush = 1; in_valid = 1;
    #1 chk("flush_ready", in_ready, 0);
    cycle();
    chk("flush_valid", ex_valid, 0);
    flush = 0; in_valid = 0;
    cycle();
    chk("flush_no_accept", ex_valid, 0);

    // Randomized run with one asynchronous reset mid-way
    for (int i = 0; i < 400; i++) begin
      randomize_inputs();
      if (i == 200) begin
        rst_n = 0;
        #1;
        chk("async_rst_valid", ex_valid, 0);
        chk("async_rst_a", alu_a, 0);
        chk("async_rst_ctl", alu_control, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1;
      end
      cycle();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/ex_operand_stage.md
# ex_operand_stage

ID/EX pipeline stage that sits directly upstream of the 16-bit ALU. It accepts one decoded instruction per cycle over a valid/ready handshake and resolves operand forwarding from the EX/MEM and MEM/WB stages. It detects load-use hazards, generates the 4-bit ALU control code from ALUOp/funct, and holds registered operands `alu_a`/`alu_b`/`alu_control` that drive the ALU combinationally during EX.

## Interface
- `DATA_W`, 16, datapath width; must match ALU width.
- `REG_AW`, 2, register-address width (4 registers; register 0 reads as zero).
- `IMM_W`, 8, immediate width, sign-extended to `DATA_W`.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  decoded instruction presented.
- `in_ready`  out  1  stage accepts the presented instruction this cycle.
- `in_rs`, `in_rt`, `in_rd`  in  REG_AW each  source and destination register numbers.
- `in_rs_data`, `in_rt_data`  in  DATA_W each  register-file read data.
- `in_imm`  in  IMM_W  raw immediate.
- `in_alu_src`  in  1  1 = B operand is the sign-extended immediate.
- `in_alu_op`  in  2  00 add, 01 sub, 10 R-type (use funct), 11 or.
- `in_funct`  in  6  R-type function field.
- `in_reg_write`, `in_mem_read`, `in_mem_write`  in  1 each  control bits carried forward.
- `flush`  in  1  kill the held entry; block acceptance this cycle.
- `exmem_we`, `exmem_load`  in  1 each  EX/MEM writes a register; EX/MEM holds a load.
- `exmem_rd`  in  REG_AW  EX/MEM destination register.
- `exmem_data`  in  DATA_W  EX/MEM ALU result.
- `memwb_we`  in  1  MEM/WB writes a register.
- `memwb_rd`  in  REG_AW  MEM/WB destination register.
- `memwb_data`  in  DATA_W  MEM/WB writeback data.
- `ex_valid`  out  1  held entry valid.
- `ex_ready`  in  1  downstream EX/MEM consumes the held entry.
- `alu_a`, `alu_b`  out  DATA_W each  ALU operands.
- `alu_control`  out  4  ALU control code.
- `ex_store_data`  out  DATA_W  forwarded rt value, for stores.
- `ex_rd`  out  REG_AW  destination register.
- `ex_reg_write`, `ex_mem_read`, `ex_mem_write`  out  1 each  carried control bits.

## Operation
- Accept: an instruction is accepted when `in_valid && in_ready`. It is captured into the stage register at that edge, and `ex_valid` is 1 on the next cycle.
- `in_ready` = `!flush && !hazard && (!ex_valid || ex_ready)`.
- Uses: `uses_rs` = 1 always. `uses_rt` = `!in_alu_src || in_mem_write`.
- `hazard` is 1 when a used source register is nonzero and either:
  - (a) `ex_valid && ex_mem_read && ex_reg_write && ex_rd == src` (load held in this stage), or
  - (b) `exmem_load && exmem_we && exmem_rd == src`.
- A load followed by a dependent instruction therefore costs two bubbles. The operand is then taken from MEM/WB.
- Forwarding is applied at capture, per source. Priority:
  1. EX/MEM (`exmem_we`, rd match, `!exmem_load`)
  2. MEM/WB (`memwb_we`, rd match)
  3. register-file data
- Register 0 never forwards; its value is always the input data.
- Hold snoop: while `ex_valid && !ex_ready`, any MEM/WB write to the held rs updates `alu_a`. A MEM/WB write to the held rt updates `ex_store_data`, and also `alu_b` when `!alu_src`.
- B operand: `alu_src` selects `{{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm}`; otherwise the forwarded rt value. `ex_store_data` is always the forwarded rt value.
- ALU control mapping:
  - alu_op 00 → 0010; 01 → 0110; 11 → 0001.
  - alu_op 10 with funct 100000 → 0010; 100010 → 0110; 100100 → 0000; 100101 → 0001; 101010 → 0111; 100111 → 1100.
  - Any other funct → 1111 (ALU outputs 0).
- Retire: when `ex_valid && ex_ready` and no new accept, `ex_valid` drops to 0. An accept in the same cycle replaces the entry with no bubble.
- Flush: at the next edge `ex_valid` = 0 and no input is accepted. Flush wins over `in_valid` and `ex_ready`. Data registers may retain stale values.
- `ex_rd` is `in_rd`, as selected by the decoder.

## Timing
- Reset (async, `rst_n` low): `ex_valid`=0. `alu_a`, `alu_b`, `ex_store_data` = 0. `alu_control`=0000. `ex_rd`=0. All control outputs 0. `in_ready` follows its equation, so it is 1 after reset when no hazard is present.
- Reset asserted mid-operation discards the held entry immediately; no partial state survives.
- Latency: 1 cycle from accept to `ex_valid`. Throughput: 1 instruction per cycle while `ex_ready`=1 and no hazards.
- All outputs except `in_ready` are registered. `in_ready` is combinational from `flush`, hazard inputs, `ex_valid` and `ex_ready`.
- Outputs remain stable while `ex_valid && !ex_ready`, except for snoop updates, which take effect at the edge after the MEM/WB write.

## Test plan
- Reset: hold `rst_n`=0 with random inputs → all outputs 0, `ex_valid`=0. Release with no hazard → `in_ready`=1.
- R-type add: rs_data 0x0005, rt_data 0x0003, alu_op 10, funct 100000 → next cycle `ex_valid`=1, `alu_a`=0x0005, `alu_b`=0x0003, `alu_control`=0010.
- Immediate: alu_src 1, imm 0xFC, alu_op 00 → `alu_b`=0xFFFC, `alu_control`=0010. Funct 111111 with alu_op 10 → 1111.
- Forwarding priority:
  - rs=1, rs_data 0x0000, EX/MEM rd 1 data 0x1111 we, MEM/WB rd 1 data 0x2222 we → `alu_a`=0x1111.
  - Same with `exmem_load`=1 → `in_ready`=0.
  - Same with rs=0 → `alu_a`=0x0000.
- Load-use: held load rd=2; present rs=2 → `in_ready`=0 for 2 cycles. The instruction is captured with `alu_a`=`memwb_data` when the load is at MEM/WB.
- Backpressure and flush:
  - `ex_ready`=0 for 3 cycles → outputs held, `in_ready`=0. A MEM/WB write to the held rs in that window updates `alu_a` at the next edge.
  - `flush` together with `in_valid` → `ex_valid`=0 at the next edge, and the input is not accepted.
